// File: rtl/push_button_conditioner.sv
// Synchronises, debounces and edge-detects the raw board push buttons.
// Optional auto-repeat of press pulses while held: define BTN_REPEAT_EN.
module push_button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_BTN        = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] push,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             step_pulse,
  output logic             any_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      STEP_BTN < 0 || STEP_BTN >= N_BTN) begin : g_bad_params
    $error("push_button_conditioner: illegal parameter combination");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          accept;
    logic          rpt_fire;

    // A new level is accepted once s2 has differed for DEBOUNCE_CYCLES cycles.
    assign accept = (s2 != level_q) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= push[i];
        s2 <= s1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= (accept && !level_q) || rpt_fire;
        release_q <= accept && level_q;
        if (s2 == level_q) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          level_q <= ~level_q;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_periodic;

    // An edge that accepts a release never carries a repeat pulse.
    assign rpt_fire = level_q && !accept &&
                      (rpt_cnt == (rpt_periodic ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt      <= '0;
        rpt_periodic <= 1'b0;
      end else if (!level_q || accept) begin
        rpt_cnt      <= '0;
        rpt_periodic <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt      <= '0;
        rpt_periodic <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

  assign step_pulse = btn_press[STEP_BTN];
  assign any_level  = |btn_level;

endmodule

// File: doc/push_button_conditioner.md
Name: push_button_conditioner

Overview:
- Board-side receiver for the `push[3:0]` button inputs of the CPU top level.
- Synchronises, debounces and edge-detects each button, then delivers clean levels and single-cycle press/release pulses to the CPU core.
- Those pulses are used as single-step clock enables and soft-reset requests.
- Sits between the board pins and the pipeline control logic inside `top`.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); minimum legal value 2.
- STEP_BTN, 2, index of the button whose press drives `step_pulse`.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  N_BTN  raw, asynchronous, bouncing button inputs; active-high.
- btn_level  output  N_BTN  debounced level per button.
- btn_press  output  N_BTN  one-cycle pulse per button on an accepted 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse per button on an accepted 1->0 transition.
- step_pulse  output  1  equals `btn_press[STEP_BTN]`, registered identically.
- any_level  output  1  OR of `btn_level`.

Behaviour:
- Reset: `rst_n` low asynchronously clears all of the following:
  - sync flops, counters and repeat state;
  - `btn_level`, `btn_press`, `btn_release` and `step_pulse` to 0;
  - `any_level` to 0.
- Channels are fully independent. Simultaneous activity on several buttons is processed in parallel with no priority.
- Synchroniser: each channel has two flops, `s1` <= `push[i]` and `s2` <= `s1`. Only `s2` feeds the debouncer.
- Debounce counter: per channel, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == btn_level[i]`: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: `btn_level[i]` toggles, counter <= 0.
  - Else: counter increments by 1.
- Latency: an input level first sampled at edge k appears on `btn_level` at edge k+DEBOUNCE_CYCLES+1, provided `push` is held constant throughout.
- Glitch rejection: any excursion of `s2` shorter than DEBOUNCE_CYCLES cycles produces no change on any output, and the counter restarts from 0 on each return to the current level.
- Pulses:
  - `btn_press[i]` is registered and high for exactly one cycle, on the same edge that `btn_level[i]` rises.
  - `btn_release[i]` behaves the same way for falls.
  - Press and release of the same channel are never high together.
- Reset mid-operation: a button held during reset release is seen as a new press. `btn_press` fires DEBOUNCE_CYCLES+2 edges after `rst_n` deasserts, counting from the first sampling edge.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Each channel gains a repeat counter that clears whenever `btn_level[i]` is 0 or on the accepted press.
  - While held, an extra one-cycle `btn_press[i]` pulse (and `step_pulse` for STEP_BTN) fires REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles thereafter.
  - Release stops repeats immediately; no repeat pulse coincides with `btn_release`.
- Undefined: no repeat logic is built; exactly one press pulse per accepted press, and the REPEAT_* parameters are ignored.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, STEP_BTN=2, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset -> hold `rst_n`=0 and `push`=4'b1111 -> all outputs 0 throughout. After release, `btn_level`=4'b1111 on edge 5 and `btn_press`=4'b1111 for that single cycle.
2. Clean press -> `push`=4'b0100 sampled at edge 0 and held -> edge 5: `btn_level`=4'b0100, `btn_press`=4'b0100, `step_pulse`=1, all for one cycle. Edge 6: `btn_press`=0, `step_pulse`=0.
3. Bounce -> `push[0]` toggles 1,0,1,1,0,1 (one change per cycle), then held at 1 -> no output change until 4 consecutive stable `s2` cycles. Then exactly one `btn_press[0]` pulse.
4. Release -> from `btn_level`=4'b0100 set `push`=0 -> `btn_release`=4'b0100 for one cycle at edge 5 after first sampling, `btn_level`=0, `any_level`=0.
5. Simultaneous -> `push[1]` and `push[3]` rise on the same edge -> both `btn_level` bits and both press pulses assert on the same edge. `step_pulse` stays 0.
6. Repeat (BTN_REPEAT_EN defined) -> hold `push[2]` for 30 cycles after acceptance -> press pulses at accept+0, +10, +13, +16, … while held. With the macro undefined, only the accept+0 pulse occurs.
